// File: rtl/main_control_fsm.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback and drives all datapath controls.
// Latency: outputs are Moore-decoded from state (PCEn also uses Zero combinationally); LW 5, SW/R/ADDI 4, BEQ/J 3, illegal 2 cycles.
// Backpressure: none; the controller advances every cycle and only pauses via reset.
module main_control_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;
    logic   op_known;

    assign op_known = (Op == OP_LW) || (Op == OP_SW) || (Op == OP_RTYPE) ||
                      (Op == OP_BEQ) || (Op == OP_ADDI) || (Op == OP_J);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH:   state_nxt = DECODE;
            DECODE: begin
                if ((Op == OP_LW) || (Op == OP_SW)) state_nxt = MEMADR;
                else if (Op == OP_RTYPE)            state_nxt = RTYPEEX;
                else if (Op == OP_BEQ)              state_nxt = BEQEX;
                else if (Op == OP_ADDI)             state_nxt = ADDIEX;
                else if (Op == OP_J)                state_nxt = JEX;
                else                                state_nxt = FETCH;
            end
            MEMADR:  state_nxt = (Op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_nxt = MEMWB;
            RTYPEEX: state_nxt = RTYPEWB;
            ADDIEX:  state_nxt = ADDIWB;
            default: state_nxt = FETCH;
        endcase
    end

    // Decode leaves one-bit fields at 0 unless named; DECODE precomputes the branch target into ALUOut.
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.irwrite = 1'b1;
                ctrl.alusrcb = 2'b01;
                ctrl.pcwrite = 1'b1;
            end
            DECODE:  ctrl.alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
            end
            MEMRD:   ctrl.iord = 1'b1;
            MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = 2'b10;
            end
            RTYPEWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = 2'b01;
                ctrl.pcsrc   = 2'b01;
                ctrl.branch  = 1'b1;
            end
            ADDIWB:  ctrl.regwrite = 1'b1;
            JEX: begin
                ctrl.pcsrc   = 2'b10;
                ctrl.pcwrite = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    // Reset silences every output, including the debug state view.
    always_comb begin
        IorD     = ~reset & ctrl.iord;
        MemWrite = ~reset & ctrl.memwrite;
        IRWrite  = ~reset & ctrl.irwrite;
        RegDst   = ~reset & ctrl.regdst;
        MemtoReg = ~reset & ctrl.memtoreg;
        RegWrite = ~reset & ctrl.regwrite;
        ALUSrcA  = ~reset & ctrl.alusrca;
        ALUSrcB  = reset ? 2'b00 : ctrl.alusrcb;
        ALUOp    = reset ? 2'b00 : ctrl.aluop;
        PCSrc    = reset ? 2'b00 : ctrl.pcsrc;
        PCEn     = ~reset & (ctrl.pcwrite | (ctrl.branch & Zero));
        Illegal  = ~reset & (state == DECODE) & ~op_known;
        State    = reset ? 4'd0 : state;
    end

endmodule
